alu_arb_sched: RTL and testbench
================================

ALU_ARB_SCHED -- requirements
Module: alu_arb_sched

Interface
REQ-001 Parameter RR_INIT, default 0: the requester that holds priority after reset (0 or 1).
REQ-002 Clock is clk; reset is rst, asynchronous, active-high.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 req_valid  input  [1:0]  per-requester request valid.
REQ-006 req_ready  output  [1:0]  per-requester grant; one-hot or zero.
REQ-007 req_op  input  [3:0]  2 bits per requester: 00 add, 01 sub, 10 mul, 11 div.
REQ-008 req_a, req_b  input  [7:0] each  4 bits per requester; signed two's-complement operands.
REQ-009 resp_valid  output  1  result available.
REQ-010 resp_ready  input  1  consumer accepts the result.
REQ-011 resp_id  output  1  index of the requester that owns the result.
REQ-012 resp_result  output  8  signed result.
REQ-013 resp_rem  output  4  signed remainder; div only, 0 otherwise.
REQ-014 resp_err  output  1  division by zero, or unsupported op.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, EXEC and RESP.
REQ-017 In IDLE, req_ready SHALL assert combinationally for exactly one requester with req_valid high, selected by round-robin. A transfer occurs on the edge where valid and ready are both high.
REQ-018 Round-robin: with both valid, grant goes to the priority holder; after any grant, priority moves to the other requester.
REQ-019 On accept, op, operands and id SHALL be latched, and the FSM SHALL go to EXEC with cycle count N: add/sub N=1, mul N=4, div N=4.
REQ-020 resp_valid SHALL rise exactly N edges after the accepting edge (FSM in RESP). req_ready SHALL stay 0 outside IDLE.
REQ-021 In RESP, all resp_* outputs SHALL hold stable until the edge where resp_ready=1; the FSM then returns to IDLE. There is no accept on that same edge.
REQ-022 Add/sub: 5-bit exact result, sign-extended to 8 bits, with no overflow.
REQ-023 Mul: exact 8-bit signed product, computed by 4 iterative shift-add steps on magnitudes with sign correction.
REQ-024 Div: 4-step restoring division on magnitudes.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - -8/-1 = +8 (8'h08).
REQ-025 Div with b=0: resp_err=1, resp_result=8'h00, resp_rem=4'h0, with normal latency N=4.
REQ-026 Operand or op changes on a requester's inputs after acceptance SHALL NOT affect the result in flight.
REQ-027 When the FSM leaves RESP, resp_valid SHALL fall, and resp_result/resp_rem SHALL retain their last values.

Reset
REQ-028 On rst, all outputs SHALL be 0, the FSM SHALL be in IDLE, the step counter SHALL be 0, and priority SHALL equal RR_INIT.
REQ-029 Reset asserted mid-EXEC or mid-RESP SHALL abort the operation; no response is delivered for it.

Configuration
REQ-030 Macro ALU_ARB_DIV_EN SHALL control the divider.
  - Defined: divider is compiled in and op 11 behaves as in REQ-024/025.
  - Undefined: divider logic is absent; op 11 completes with N=1, resp_err=1, resp_result=0, resp_rem=0.

Structure
REQ-031 A shared package alu_pkg SHALL hold:
  - the op encodings ALU_OP_ADD/SUB/MUL/DIV;
  - the FSM state enumeration;
  - the per-op latency constants.
REQ-032 The iterative mul/div datapath SHALL be the sub-module alu_iter_core, with start/done/op/a/b inputs and outputs. The arbiter and FSM stay in alu_arb_sched.

Verification
REQ-033 Req0 add a=7, b=7 -> resp_valid 1 edge after accept, result 8'h0E, id 0, err 0.
REQ-034 Req1 sub a=-8, b=7 -> result 8'hF1 (-15); mul a=-3, b=5 -> result 8'hF1 after 4 edges, rem 0.
REQ-035 Div a=-7, b=2 -> result 8'hFD (-3), rem 4'hF (-1); div a=5, b=0 -> err 1, result 8'h00 after 4 edges.
REQ-036 Both requesters continuously valid, RR_INIT=0, resp_ready tied 1 -> grant sequence 0,1,0,1; resp_result held stable while resp_ready=0 for 3 cycles.
REQ-037 rst pulsed during mul EXEC -> no resp_valid, busy=0, priority=RR_INIT; the next request completes correctly.
REQ-038 Build without ALU_ARB_DIV_EN; div a=6, b=3 -> resp after 1 edge, err 1, result 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op encodings, FSM states and per-op latencies for alu_arb_sched.
// ALU_ARB_DIV_EN compiles in the divider; without it op 11 finishes in one cycle as an error.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_OP_ADD = 2'b00,
        ALU_OP_SUB = 2'b01,
        ALU_OP_MUL = 2'b10,
        ALU_OP_DIV = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_e;

    localparam int unsigned CNT_W = 3;

    localparam logic [CNT_W-1:0] LAT_ADD = 3'd1;
    localparam logic [CNT_W-1:0] LAT_SUB = 3'd1;
    localparam logic [CNT_W-1:0] LAT_MUL = 3'd4;
`ifdef ALU_ARB_DIV_EN
    localparam bit               DIV_EN  = 1'b1;
    localparam logic [CNT_W-1:0] LAT_DIV = 3'd4;
`else
    localparam bit               DIV_EN  = 1'b0;
    localparam logic [CNT_W-1:0] LAT_DIV = 3'd1;
`endif

    function automatic logic [CNT_W-1:0] op_latency(input alu_op_e op);
        case (op)
            ALU_OP_ADD: return LAT_ADD;
            ALU_OP_SUB: return LAT_SUB;
            ALU_OP_MUL: return LAT_MUL;
            default:    return LAT_DIV;
        endcase
    endfunction

    // Ops that run on the iterative core rather than completing from the latched operands.
    function automatic logic op_is_iter(input alu_op_e op);
        return (op == ALU_OP_MUL) || (DIV_EN && (op == ALU_OP_DIV));
    endfunction

    // Magnitude of a 4-bit two's-complement value; -8 maps to 4'd8.
    function automatic logic [3:0] mag4(input logic [3:0] v);
        return v[3] ? (4'h0 - v) : v;
    endfunction

endpackage

// File: rtl/alu_arb_sched_if.sv
// Request/response bus of alu_arb_sched: two requesters in, one result stream out.
interface alu_arb_sched_if;

    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [3:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       resp_valid;
    logic       resp_ready;
    logic       resp_id;
    logic [7:0] resp_result;
    logic [3:0] resp_rem;
    logic       resp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_result, resp_rem, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_result, resp_rem, resp_err
    );

endinterface

// File: rtl/alu_iter_core.sv
// Four-step shift-add multiplier and restoring divider on operand magnitudes.
// The divider step exists only when ALU_ARB_DIV_EN is defined.
module alu_iter_core
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  alu_op_e    op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       done,
    output logic [7:0] result,
    output logic [3:0] rem
);

    logic       busy_q;
    logic [1:0] step_q;
    logic       div_q;
    logic       neg_q;
    logic       a_neg_q;
    logic       zero_q;
    // mul: acc = partial product, x = shifted multiplicand, y = multiplier
    // div: acc = partial remainder, x = divisor, y = dividend shifting into quotient
    logic [7:0] acc_q, acc_d;
    logic [7:0] x_q, x_d;
    logic [3:0] y_q, y_d;
`ifdef ALU_ARB_DIV_EN
    logic [4:0] rtmp;
`endif

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        acc_d = acc_q;
        x_d   = x_q;
        y_d   = y_q;
`ifdef ALU_ARB_DIV_EN
        rtmp  = {acc_q[3:0], y_q[3]};
`endif
        if (!div_q) begin
            if (y_q[0]) acc_d = acc_q + x_q;
            x_d = x_q << 1;
            y_d = y_q >> 1;
        end
`ifdef ALU_ARB_DIV_EN
        else begin
            y_d = {y_q[2:0], 1'b0};
            if (rtmp >= {1'b0, x_q[3:0]}) begin
                acc_d  = {3'b000, rtmp - {1'b0, x_q[3:0]}};
                y_d[0] = 1'b1;
            end else begin
                acc_d = {3'b000, rtmp};
            end
        end
`endif
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= 1'b0;
            step_q  <= 2'd0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            a_neg_q <= 1'b0;
            zero_q  <= 1'b0;
            acc_q   <= 8'h00;
            x_q     <= 8'h00;
            y_q     <= 4'h0;
        end else if (start) begin
            busy_q  <= 1'b1;
            step_q  <= 2'd0;
            div_q   <= DIV_EN && (op == ALU_OP_DIV);
            neg_q   <= a[3] ^ b[3];
            a_neg_q <= a[3];
            zero_q  <= (b == 4'h0);
            acc_q   <= 8'h00;
            if (DIV_EN && (op == ALU_OP_DIV)) begin
                x_q <= {4'h0, mag4(b)};
                y_q <= mag4(a);
            end else begin
                x_q <= {4'h0, mag4(a)};
                y_q <= mag4(b);
            end
        end else if (busy_q) begin
            acc_q  <= acc_d;
            x_q    <= x_d;
            y_q    <= y_d;
            step_q <= step_q + 2'd1;
            if (step_q == 2'd3) busy_q <= 1'b0;
        end
    end

    // High during the cycle whose closing edge performs the last step.
    assign done = busy_q && (step_q == 2'd3);

    logic [7:0] mag;
    assign mag    = div_q ? {4'h0, y_q} : acc_q;
    assign result = (div_q && zero_q) ? 8'h00 : (neg_q ? (8'h00 - mag) : mag);
    assign rem    = (div_q && !zero_q) ? (a_neg_q ? (4'h0 - acc_q[3:0]) : acc_q[3:0]) : 4'h0;

endmodule

// File: rtl/alu_arb_sched.sv
// Two-requester round-robin front end sharing one small ALU, with an IDLE/EXEC/RESP scheduler.
// Divider availability follows ALU_ARB_DIV_EN through alu_pkg.
module alu_arb_sched
    import alu_pkg::*;
#(
    parameter bit RR_INIT = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    alu_arb_sched_if.slave bus,
    output logic           busy
);

    state_e           state_q, state_d;
    logic             prio_q;
    logic [CNT_W-1:0] cnt_q;
    logic             id_q;
    alu_op_e          op_q;
    logic [3:0]       a_q, b_q;

    logic [1:0] grant;
    logic       gid;
    logic       accept;
    alu_op_e    sel_op;
    logic [3:0] sel_a, sel_b;
    logic       core_done;
    logic [7:0] core_result;
    logic [3:0] core_rem;
    logic       exec_last;

    // Priority only matters when both requesters compete.
    always_comb begin
        grant = bus.req_valid;
        if (bus.req_valid == 2'b11) grant = prio_q ? 2'b10 : 2'b01;
    end

    assign gid           = grant[1];
    assign accept        = (state_q == ST_IDLE) && (grant != 2'b00);
    assign bus.req_ready = ((state_q == ST_IDLE) && !rst) ? grant : 2'b00;
    assign sel_op        = alu_op_e'(bus.req_op[{gid, 1'b0} +: 2]);
    assign sel_a         = bus.req_a[{gid, 2'b00} +: 4];
    assign sel_b         = bus.req_b[{gid, 2'b00} +: 4];

    alu_iter_core u_core (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && op_is_iter(sel_op)),
        .op     (sel_op),
        .a      (sel_a),
        .b      (sel_b),
        .done   (core_done),
        .result (core_result),
        .rem    (core_rem)
    );

    assign exec_last = op_is_iter(op_q) ? core_done : (cnt_q == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept)         state_d = ST_EXEC;
            ST_EXEC: if (exec_last)      state_d = ST_RESP;
            ST_RESP: if (bus.resp_ready) state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= RR_INIT;
            cnt_q  <= '0;
            id_q   <= 1'b0;
            op_q   <= ALU_OP_ADD;
            a_q    <= 4'h0;
            b_q    <= 4'h0;
        end else if (accept) begin
            prio_q <= ~gid;
            cnt_q  <= op_latency(sel_op);
            id_q   <= gid;
            op_q   <= sel_op;
            a_q    <= sel_a;
            b_q    <= sel_b;
        end else if (state_q == ST_EXEC) begin
            cnt_q  <= cnt_q - CNT_W'(1);
        end
    end

    // Results derive only from latched state, so they hold through RESP and after it.
    logic [4:0] sum;
    logic [7:0] res;
    logic [3:0] rem;
    logic       err;

    always_comb begin
        sum = 5'h00;
        res = 8'h00;
        rem = 4'h0;
        err = 1'b0;
        unique case (op_q)
            ALU_OP_ADD: begin
                sum = {a_q[3], a_q} + {b_q[3], b_q};
                res = {{3{sum[4]}}, sum};
            end
            ALU_OP_SUB: begin
                sum = {a_q[3], a_q} - {b_q[3], b_q};
                res = {{3{sum[4]}}, sum};
            end
            ALU_OP_MUL: res = core_result;
            default: begin
                err = !DIV_EN || (b_q == 4'h0);
                if (DIV_EN) begin
                    res = core_result;
                    rem = core_rem;
                end
            end
        endcase
    end

    assign bus.resp_valid  = (state_q == ST_RESP);
    assign bus.resp_id     = id_q;
    assign bus.resp_result = res;
    assign bus.resp_rem    = rem;
    assign bus.resp_err    = err;
    assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arb_sched.sv
// Directed scoreboard bench for alu_arb_sched; expectations adapt to ALU_ARB_DIV_EN.
`timescale 1ns/1ps
module tb_alu_arb_sched;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    always #5 clk = ~clk;

    alu_arb_sched_if bus ();

    alu_arb_sched #(.RR_INIT(1'b0)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    typedef struct {
        logic       id;
        logic [7:0] res;
        logic [3:0] rem;
        logic       err;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arithmetic on signed integers.
    function automatic exp_t model(input logic id, input logic [1:0] op,
                                   input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        int   sa, ob, r;
        sa    = int'($signed(a));
        ob    = int'($signed(b));
        e.id  = id;
        e.res = 8'h00;
        e.rem = 4'h0;
        e.err = 1'b0;
        e.lat = 1;
        case (op)
            2'b00: begin r = sa + ob; e.res = r[7:0]; end
            2'b01: begin r = sa - ob; e.res = r[7:0]; end
            2'b10: begin r = sa * ob; e.res = r[7:0]; e.lat = 4; end
            default: begin
`ifdef ALU_ARB_DIV_EN
                e.lat = 4;
                if (ob == 0) begin
                    e.err = 1'b1;
                end else begin
                    r = sa / ob; e.res = r[7:0];
                    r = sa % ob; e.rem = r[3:0];
                end
`else
                e.err = 1'b1;
`endif
            end
        endcase
        return e;
    endfunction

    // Present one request, confirm the grant, complete the accept, then disturb its inputs.
    task automatic send(input logic id, input logic [1:0] op, input logic [3:0] a,
                        input logic [3:0] b, input string tag);
        int idx;
        idx = int'(id);
        sb.push_back(model(id, op, a, b));
        bus.req_op = 4'($urandom);
        bus.req_a  = 8'($urandom);
        bus.req_b  = 8'($urandom);
        bus.req_op[idx*2 +: 2] = op;
        bus.req_a[idx*4 +: 4]  = a;
        bus.req_b[idx*4 +: 4]  = b;
        bus.req_valid          = 2'b00;
        bus.req_valid[idx]     = 1'b1;
        #1;
        check({tag, " req_ready"}, bus.req_ready, id ? 2'b10 : 2'b01);
        tick();
        bus.req_valid          = 2'b00;
        bus.req_op[idx*2 +: 2] = 2'($urandom);
        bus.req_a[idx*4 +: 4]  = 4'($urandom);
        bus.req_b[idx*4 +: 4]  = 4'($urandom);
        check({tag, " busy"}, busy, 1'b1);
        check({tag, " ready_exec"}, bus.req_ready, 2'b00);
    endtask

    task automatic wait_resp(input string tag, input bit chk_lat, output exp_t e);
        int lat;
        lat = 0;
        e   = '{id: 1'b0, res: 8'h00, rem: 4'h0, err: 1'b0, lat: 0};
        while (!bus.resp_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, " resp_valid"}, bus.resp_valid, 1'b1);
        check({tag, " sb_nonempty"}, sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (chk_lat) check({tag, " latency"}, lat, e.lat);
            check({tag, " id"}, bus.resp_id, e.id);
            check({tag, " result"}, bus.resp_result, e.res);
            check({tag, " rem"}, bus.resp_rem, e.rem);
            check({tag, " err"}, bus.resp_err, e.err);
        end
    endtask

    task automatic finish_resp(input string tag, input exp_t e);
        tick();
        check({tag, " valid_fall"}, bus.resp_valid, 1'b0);
        check({tag, " idle"}, busy, 1'b0);
        check({tag, " result_kept"}, bus.resp_result, e.res);
        check({tag, " rem_kept"}, bus.resp_rem, e.rem);
    endtask

    task automatic do_op(input logic id, input logic [1:0] op, input logic [3:0] a,
                         input logic [3:0] b, input string tag);
        exp_t e;
        send(id, op, a, b, tag);
        wait_resp(tag, 1'b1, e);
        finish_resp(tag, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   got, cyc, seen;

        rst            = 1'b1;
        bus.req_valid  = 2'b00;
        bus.req_op     = 4'h0;
        bus.req_a      = 8'h00;
        bus.req_b      = 8'h00;
        bus.resp_ready = 1'b1;
        #1;
        check("rst busy", busy, 1'b0);
        check("rst resp_valid", bus.resp_valid, 1'b0);
        check("rst req_ready", bus.req_ready, 2'b00);
        check("rst result", bus.resp_result, 8'h00);
        check("rst rem", bus.resp_rem, 4'h0);
        check("rst err", bus.resp_err, 1'b0);
        check("rst id", bus.resp_id, 1'b0);
        #12;
        rst = 1'b0;
        tick();

        do_op(1'b0, ALU_OP_ADD, 4'd7, 4'd7, "add_7_7");
        do_op(1'b1, ALU_OP_SUB, 4'h8, 4'd7, "sub_m8_7");
        do_op(1'b1, ALU_OP_MUL, 4'hD, 4'd5, "mul_m3_5");
        do_op(1'b0, ALU_OP_MUL, 4'h8, 4'h8, "mul_m8_m8");
        do_op(1'b1, ALU_OP_MUL, 4'd7, 4'h8, "mul_7_m8");
        do_op(1'b0, ALU_OP_ADD, 4'h8, 4'h8, "add_m8_m8");
        do_op(1'b0, ALU_OP_SUB, 4'd7, 4'h8, "sub_7_m8");
        do_op(1'b1, ALU_OP_DIV, 4'h9, 4'd2, "div_m7_2");
        do_op(1'b0, ALU_OP_DIV, 4'd5, 4'd0, "div_5_0");
        do_op(1'b1, ALU_OP_DIV, 4'h8, 4'hF, "div_m8_m1");
        do_op(1'b0, ALU_OP_DIV, 4'd6, 4'd3, "div_6_3");
        do_op(1'b1, ALU_OP_DIV, 4'd7, 4'hD, "div_7_m3");

        // Consumer stalls for three cycles while another request waits.
        bus.resp_ready = 1'b0;
        send(1'b1, ALU_OP_MUL, 4'd3, 4'd3, "hold");
        wait_resp("hold", 1'b1, e);
        bus.req_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold valid", bus.resp_valid, 1'b1);
            check("hold result", bus.resp_result, e.res);
            check("hold id", bus.resp_id, e.id);
            check("hold no_grant", bus.req_ready, 2'b00);
        end
        bus.req_valid  = 2'b00;
        bus.resp_ready = 1'b1;
        finish_resp("hold", e);

        // Both requesters continuously valid from a fresh reset.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        bus.req_op = {ALU_OP_SUB, ALU_OP_ADD};
        bus.req_a  = {4'd2, 4'd3};
        bus.req_b  = {4'd5, 4'd4};
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) sb.push_back(model(1'b0, ALU_OP_ADD, 4'd3, 4'd4));
            else            sb.push_back(model(1'b1, ALU_OP_SUB, 4'd2, 4'd5));
        end
        bus.req_valid = 2'b11;
        #1;
        check("rr first_grant", bus.req_ready, 2'b01);
        got = 0;
        cyc = 0;
        while (got < 4 && cyc < 60) begin
            tick();
            cyc++;
            if (bus.resp_valid) begin
                wait_resp("rr", 1'b0, e);
                got++;
            end
        end
        bus.req_valid = 2'b00;
        check("rr responses", got, 4);
        tick();
        check("rr idle", busy, 1'b0);

        // Reset in the middle of a multiply aborts it and restores priority.
        send(1'b0, ALU_OP_MUL, 4'd2, 4'hD, "abort");
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("abort busy", busy, 1'b0);
        check("abort resp_valid", bus.resp_valid, 1'b0);
        check("abort req_ready", bus.req_ready, 2'b00);
        check("abort result", bus.resp_result, 8'h00);
        rst = 1'b0;
        sb.delete();
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.resp_valid) seen++;
        end
        check("abort no_resp", seen, 0);

        bus.req_op = {ALU_OP_ADD, ALU_OP_MUL};
        bus.req_a  = {4'd1, 4'd2};
        bus.req_b  = {4'd1, 4'hD};
        sb.push_back(model(1'b0, ALU_OP_MUL, 4'd2, 4'hD));
        bus.req_valid = 2'b11;
        #1;
        check("post_rst prio", bus.req_ready, 2'b01);
        tick();
        bus.req_valid = 2'b00;
        wait_resp("post_rst", 1'b1, e);
        finish_resp("post_rst", e);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
